// File: rtl/riscv_i32c_fetch_align.sv
// Fetch sequencer and halfword aligner for an RV32IC/RV32EC decoder.
// Issues word-aligned fetches and queues the returned halfwords. It presents
// one complete 16-bit or 32-bit instruction per handshake, including 32-bit
// instructions that straddle a word boundary and halfword-aligned redirects.
module riscv_i32c_fetch_align #(
  parameter int unsigned BUFFER_HALFWORDS = 4,
  parameter logic [31:0] RESET_PC         = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        riscv_config__i32c,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        fetch_req,
  output logic [31:0] fetch_address,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_is_compressed
);

  localparam int unsigned   CW        = $clog2(BUFFER_HALFWORDS + 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_TWO   = CW'(2);
  localparam logic [CW-1:0] REQ_LIMIT = CW'(BUFFER_HALFWORDS - 2);

  // Halfword queue; entry 0 is the oldest halfword and sits at pc_q.
  logic [15:0]   hw_buf_q [BUFFER_HALFWORDS];
  logic [15:0]   hw_buf_d [BUFFER_HALFWORDS];
  logic [15:0]   shift_s  [BUFFER_HALFWORDS];
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   fetch_address_q, fetch_address_d;
  logic          discard_half_q, discard_half_d;

  logic          is_c_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] pop_cnt_s;
  logic [CW-1:0] push_cnt_s;
  logic [CW-1:0] wr_idx_s;
  logic [15:0]   push_lo_s;
  logic          unused_flush_pc0_s;

  // Bit 0 of a redirect target carries no information for halfword-aligned code.
  assign unused_flush_pc0_s = flush_pc[0];

  // Handshake decode and instruction presentation, all from registered state.
  always_comb begin
    is_c_s     = riscv_config__i32c && (hw_buf_q[0][1:0] != 2'b11);
    instr_valid = !reset && ((count_q >= CNT_TWO) || ((count_q == CNT_ONE) && is_c_s));
    // The request looks at the count before any pop, so a push always fits.
    fetch_req  = !reset && !flush && (count_q <= REQ_LIMIT);
    push_s     = fetch_req && fetch_ack;
    pop_s      = instr_valid && instr_ready;
    pop_cnt_s  = pop_s  ? (is_c_s ? CNT_ONE : CNT_TWO) : CNT_ZERO;
    push_cnt_s = push_s ? (discard_half_q ? CNT_ONE : CNT_TWO) : CNT_ZERO;
    wr_idx_s   = count_q - pop_cnt_s;
    push_lo_s  = discard_half_q ? fetch_data[31:16] : fetch_data[15:0];
    instr_data = is_c_s ? {16'h0000, hw_buf_q[0]} : {hw_buf_q[1], hw_buf_q[0]};
    instr_pc            = pc_q;
    instr_is_compressed = is_c_s;
    fetch_address       = fetch_address_q;
  end

  // Queue contents after removing the halfwords consumed by this cycle's pop.
  always_comb begin
    shift_s = hw_buf_q;
    case (pop_cnt_s)
      CNT_ONE: begin
        for (int i = 0; i < BUFFER_HALFWORDS - 1; i++) begin
          shift_s[i] = hw_buf_q[i + 1];
        end
      end
      CNT_TWO: begin
        for (int i = 0; i < BUFFER_HALFWORDS - 2; i++) begin
          shift_s[i] = hw_buf_q[i + 2];
        end
      end
      default: begin
        shift_s = hw_buf_q;
      end
    endcase
  end

  // Next state: a redirect wins over push and pop; otherwise pop then append.
  always_comb begin
    hw_buf_d        = hw_buf_q;
    count_d         = count_q;
    pc_d            = pc_q;
    fetch_address_d = fetch_address_q;
    discard_half_d  = discard_half_q;
    if (flush) begin
      count_d         = CNT_ZERO;
      pc_d            = {flush_pc[31:1], 1'b0};
      fetch_address_d = {flush_pc[31:2], 2'b00};
      discard_half_d  = flush_pc[1];
    end else begin
      for (int i = 0; i < BUFFER_HALFWORDS; i++) begin
        if (push_s && (CW'(i) == wr_idx_s)) begin
          hw_buf_d[i] = push_lo_s;
        end else if (push_s && !discard_half_q && (CW'(i) == (wr_idx_s + CNT_ONE))) begin
          hw_buf_d[i] = fetch_data[31:16];
        end else begin
          hw_buf_d[i] = shift_s[i];
        end
      end
      count_d = count_q - pop_cnt_s + push_cnt_s;
      pc_d    = pc_q + (pop_s ? (is_c_s ? 32'd2 : 32'd4) : 32'd0);
      if (push_s) begin
        fetch_address_d = fetch_address_q + 32'd4;
        discard_half_d  = 1'b0;
      end else begin
        fetch_address_d = fetch_address_q;
        discard_half_d  = discard_half_q;
      end
    end
  end

  // State registers with synchronous reset to the boot PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUFFER_HALFWORDS; i++) begin
        hw_buf_q[i] <= 16'h0000;
      end
      count_q         <= CNT_ZERO;
      pc_q            <= RESET_PC;
      fetch_address_q <= {RESET_PC[31:2], 2'b00};
      discard_half_q  <= RESET_PC[1];
    end else begin
      hw_buf_q        <= hw_buf_d;
      count_q         <= count_d;
      pc_q            <= pc_d;
      fetch_address_q <= fetch_address_d;
      discard_half_q  <= discard_half_d;
    end
  end

endmodule

// File: tb/tb_riscv_i32c_fetch_align.sv
// Testbench for riscv_i32c_fetch_align: directed vector table, a wrap-around
// sequence and randomized traffic against a halfword-queue reference model.
module tb_riscv_i32c_fetch_align;

  localparam int BH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        riscv_config__i32c;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_req;
  logic [31:0] fetch_address;
  logic        fetch_ack;
  logic [31:0] fetch_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_is_compressed;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_fa = 32'h0;
  logic        m_disc = 1'b0;

  always #5 clk = ~clk;

  riscv_i32c_fetch_align #(.BUFFER_HALFWORDS(BH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .riscv_config__i32c(riscv_config__i32c),
    .flush(flush), .flush_pc(flush_pc), .fetch_req(fetch_req),
    .fetch_address(fetch_address), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_is_compressed(instr_is_compressed)
  );

  typedef struct {
    logic rst; logic fl; logic [31:0] fpc; logic ack; logic [31:0] data;
    logic rdy; logic c;
    logic ev; logic [31:0] ed; logic [31:0] ep; logic ec; logic er; logic [31:0] ef;
  } vec_t;

  vec_t vt [32];

  function automatic vec_t v(input logic rst, input logic fl, input logic [31:0] fpc,
                             input logic ack, input logic [31:0] data, input logic rdy,
                             input logic c, input logic ev, input logic [31:0] ed,
                             input logic [31:0] ep, input logic ec, input logic er,
                             input logic [31:0] ef);
    vec_t r;
    r.rst = rst; r.fl = fl; r.fpc = fpc; r.ack = ack; r.data = data; r.rdy = rdy; r.c = c;
    r.ev = ev; r.ed = ed; r.ep = ep; r.ec = ec; r.er = er; r.ef = ef;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic compare_outputs(input string tag, input logic ev, input logic [31:0] ed,
                                 input logic [31:0] ep, input logic ec, input logic er,
                                 input logic [31:0] ef);
    chk({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, ev});
    chk({tag, ".fetch_req"}, {31'b0, fetch_req}, {31'b0, er});
    chk({tag, ".fetch_address"}, fetch_address, ef);
    if (ev) begin
      chk({tag, ".instr_data"}, instr_data, ed);
      chk({tag, ".instr_pc"}, instr_pc, ep);
      chk({tag, ".compressed"}, {31'b0, instr_is_compressed}, {31'b0, ec});
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic [31:0] fpc, input logic ack,
                       input logic [31:0] data, input logic rdy, input logic c);
    reset = rst; flush = fl; flush_pc = fpc; fetch_ack = ack;
    fetch_data = data; instr_ready = rdy; riscv_config__i32c = c;
  endtask

  // One cycle checked against the reference model, then the model advances.
  task automatic mstep(input string tag, input logic rst, input logic fl, input logic [31:0] fpc,
                       input logic ack, input logic [31:0] data, input logic rdy, input logic c);
    int sz;
    logic isc, ev, er;
    logic [31:0] ed;
    drive(rst, fl, fpc, ack, data, rdy, c);
    #4;
    sz  = mq.size();
    isc = c && (sz > 0) && (mq[0][1:0] != 2'b11);
    ev  = !rst && ((sz >= 2) || ((sz == 1) && isc));
    er  = !rst && !fl && (sz <= BH - 2);
    ed  = 32'h0;
    if (ev) ed = isc ? {16'h0000, mq[0]} : {mq[1], mq[0]};
    compare_outputs(tag, ev, ed, m_pc, isc, er, m_fa);
    if (rst) begin
      mq.delete(); m_pc = 32'h0; m_fa = 32'h0; m_disc = 1'b0;
    end else if (fl) begin
      mq.delete(); m_pc = {fpc[31:1], 1'b0}; m_fa = {fpc[31:2], 2'b00}; m_disc = fpc[1];
    end else begin
      if (ev && rdy) begin
        void'(mq.pop_front());
        if (!isc) void'(mq.pop_front());
        m_pc = m_pc + (isc ? 32'd2 : 32'd4);
      end
      if (er && ack) begin
        if (!m_disc) mq.push_back(data[15:0]);
        mq.push_back(data[31:16]);
        m_disc = 1'b0;
        m_fa = m_fa + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic c_seg;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    //       rst fl  fpc        ack data           rdy c   ev ed             ep          ec er ef
    vt[0]  = v(1, 0, 32'h0,     0, 32'h0,          0, 1,  0, 32'h0,        32'h0,      0, 0, 32'h0);
    vt[1]  = v(0, 0, 32'h0,     1, 32'h00A00093,   0, 1,  0, 32'h0,        32'h0,      0, 1, 32'h0);
    vt[2]  = v(0, 0, 32'h0,     0, 32'h0,          1, 1,  1, 32'h00A00093, 32'h0,      0, 1, 32'h4);
    vt[3]  = v(0, 0, 32'h0,     1, 32'h45014501,   0, 1,  0, 32'h0,        32'h0,      0, 1, 32'h4);
    vt[4]  = v(0, 0, 32'h0,     0, 32'h0,          1, 1,  1, 32'h00004501, 32'h4,      1, 1, 32'h8);
    vt[5]  = v(0, 0, 32'h0,     0, 32'h0,          1, 1,  1, 32'h00004501, 32'h6,      1, 1, 32'h8);
    vt[6]  = v(0, 0, 32'h0,     1, 32'h00934501,   0, 1,  0, 32'h0,        32'h0,      0, 1, 32'h8);
    vt[7]  = v(0, 0, 32'h0,     0, 32'h0,          1, 1,  1, 32'h00004501, 32'h8,      1, 1, 32'hC);
    vt[8]  = v(0, 0, 32'h0,     0, 32'h0,          1, 1,  0, 32'h0,        32'h0,      0, 1, 32'hC);
    vt[9]  = v(0, 0, 32'h0,     1, 32'h000000A0,   1, 1,  0, 32'h0,        32'h0,      0, 1, 32'hC);
    vt[10] = v(0, 0, 32'h0,     0, 32'h0,          1, 1,  1, 32'h00A00093, 32'hA,      0, 0, 32'h10);
    vt[11] = v(0, 1, 32'h102,   1, 32'h11111111,   1, 1,  1, 32'h00000000, 32'hE,      1, 0, 32'h10);
    vt[12] = v(0, 0, 32'h0,     1, 32'h4505DEAD,   0, 1,  0, 32'h0,        32'h0,      0, 1, 32'h100);
    vt[13] = v(0, 0, 32'h0,     0, 32'h0,          0, 1,  1, 32'h00004505, 32'h102,    1, 1, 32'h104);
    vt[14] = v(0, 0, 32'h0,     1, 32'h22221111,   0, 1,  1, 32'h00004505, 32'h102,    1, 1, 32'h104);
    vt[15] = v(0, 0, 32'h0,     1, 32'h44443330,   0, 1,  1, 32'h00004505, 32'h102,    1, 0, 32'h108);
    vt[16] = v(0, 0, 32'h0,     1, 32'h44443330,   1, 1,  1, 32'h00004505, 32'h102,    1, 0, 32'h108);
    vt[17] = v(0, 0, 32'h0,     1, 32'h44443330,   0, 1,  1, 32'h00001111, 32'h104,    1, 1, 32'h108);
    vt[18] = v(0, 0, 32'h0,     1, 32'h66665555,   0, 1,  1, 32'h00001111, 32'h104,    1, 0, 32'h10C);
    vt[19] = v(0, 0, 32'h0,     1, 32'h66665555,   1, 1,  1, 32'h00001111, 32'h104,    1, 0, 32'h10C);
    vt[20] = v(0, 0, 32'h0,     1, 32'h66665555,   1, 1,  1, 32'h00002222, 32'h106,    1, 0, 32'h10C);
    vt[21] = v(0, 0, 32'h0,     1, 32'h66665555,   1, 1,  1, 32'h00003330, 32'h108,    1, 1, 32'h10C);
    vt[22] = v(0, 0, 32'h0,     0, 32'h0,          1, 1,  1, 32'h00004444, 32'h10A,    1, 0, 32'h110);
    vt[23] = v(0, 0, 32'h0,     0, 32'h0,          1, 1,  1, 32'h00005555, 32'h10C,    1, 1, 32'h110);
    vt[24] = v(0, 0, 32'h0,     0, 32'h0,          1, 1,  1, 32'h00006666, 32'h10E,    1, 1, 32'h110);
    vt[25] = v(0, 1, 32'h202,   0, 32'h0,          0, 0,  0, 32'h0,        32'h0,      0, 0, 32'h110);
    vt[26] = v(0, 0, 32'h0,     1, 32'h45019999,   0, 0,  0, 32'h0,        32'h0,      0, 1, 32'h200);
    vt[27] = v(0, 0, 32'h0,     0, 32'h0,          1, 0,  0, 32'h0,        32'h0,      0, 1, 32'h204);
    vt[28] = v(0, 0, 32'h0,     1, 32'h77770013,   1, 0,  0, 32'h0,        32'h0,      0, 1, 32'h204);
    vt[29] = v(0, 0, 32'h0,     0, 32'h0,          1, 0,  1, 32'h00134501, 32'h202,    0, 0, 32'h208);
    vt[30] = v(1, 0, 32'h0,     1, 32'h0,          1, 0,  0, 32'h0,        32'h0,      0, 0, 32'h208);
    vt[31] = v(0, 0, 32'h0,     0, 32'h0,          0, 1,  0, 32'h0,        32'h0,      0, 1, 32'h0);

    for (int i = 0; i < 32; i++) begin
      drive(vt[i].rst, vt[i].fl, vt[i].fpc, vt[i].ack, vt[i].data, vt[i].rdy, vt[i].c);
      #4;
      compare_outputs($sformatf("vec%0d", i), vt[i].ev, vt[i].ed, vt[i].ep, vt[i].ec,
                      vt[i].er, vt[i].ef);
      @(posedge clk);
      #1;
    end

    // Redirect to the last halfword of the address space: fetch address wraps.
    mq.delete(); m_pc = 32'h0; m_fa = 32'h0; m_disc = 1'b0;
    mstep("wrap", 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    mstep("wrap", 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_ABCD, 1'b1, 1'b0);
    chk("wrap.fetch_address_zero", fetch_address, 32'h0000_0000);
    chk("wrap.partial_not_valid", {31'b0, instr_valid}, 32'h0);
    mstep("wrap", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_5678, 1'b0, 1'b0);
    chk("wrap.straddle_data", instr_data, 32'h5678_1234);
    chk("wrap.straddle_pc", instr_pc, 32'hFFFF_FFFE);
    mstep("wrap", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic against the reference model.
    c_seg = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] h0, h1;
      if ((n % 250) == 249) c_seg = ~c_seg;
      h0 = 16'($urandom);
      h1 = 16'($urandom);
      mstep("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
            $urandom, ($urandom_range(0, 3) != 0), {h1, h0},
            ($urandom_range(0, 3) != 0), c_seg);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
